// File: rtl/bram_port_client_if.sv
// Request / response channel bundle between a requester and bram_port_client.
// master = the requester side, slave = bram_port_client.
interface bram_port_client_if #(
  parameter int DATA_W = 18,
  parameter int ADDR_W = 10
) ();
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_data;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_data
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_data
  );
endinterface

// File: rtl/bram_port_client.sv
// Valid/ready client for one port of a block RAM with 2-cycle registered read
// latency. Reads are tracked through a 2-stage tag pipeline and their data is
// captured into a small response FIFO. Request acceptance is throttled by an
// occupancy count (reads in flight + queued) so the FIFO can never overflow;
// writes are throttled by the same count so requests stay in order.
module bram_port_client #(
  parameter int DATA_W    = 18,
  parameter int ADDR_W    = 10,
  parameter int RSP_DEPTH = 4
) (
  input  logic              clka,
  input  logic              rsta_n,
  bram_port_client_if.slave bus,
  output logic [ADDR_W-1:0] ram_addra,
  output logic [DATA_W-1:0] ram_dina,
  output logic              ram_wea,
  output logic              ram_ena,
  output logic              ram_rsta,
  output logic              ram_regcea,
  input  logic [DATA_W-1:0] ram_douta,
  output logic [31:0]       rd_count,
  output logic [31:0]       wr_count
);

  localparam int PTR_W = $clog2(RSP_DEPTH);
  localparam int OCC_W = PTR_W + 1;
  localparam logic [OCC_W-1:0] OCC_MAX = OCC_W'(RSP_DEPTH);

  logic [OCC_W-1:0]  occ_q;
  logic [OCC_W-1:0]  fifo_cnt_q;
  logic [PTR_W-1:0]  wr_ptr_q;
  logic [PTR_W-1:0]  rd_ptr_q;
  logic [DATA_W-1:0] fifo_mem [RSP_DEPTH];
  logic              p1_q;
  logic              p2_q;
  logic [31:0]       rd_cnt_q;
  logic [31:0]       wr_cnt_q;

  logic ready;
  logic accept;
  logic rd_accept;
  logic wr_accept;
  logic push;
  logic pop;
  logic fifo_empty;
  logic fifo_full;

  // Ready depends only on reset and occupancy, never on the request itself.
  assign ready     = rsta_n & (occ_q < OCC_MAX);
  assign accept    = bus.req_valid & ready;
  assign rd_accept = accept & ~bus.req_we;
  assign wr_accept = accept & bus.req_we;

  assign bus.req_ready = ready;

  // RAM port driven straight from the accepted request.
  assign ram_ena    = accept;
  assign ram_wea    = bus.req_we & accept;
  assign ram_addra  = bus.req_addr;
  assign ram_dina   = bus.req_wdata;
  assign ram_regcea = 1'b1;
  assign ram_rsta   = ~rsta_n;

  assign fifo_empty   = (fifo_cnt_q == '0);
  assign fifo_full    = (fifo_cnt_q == OCC_MAX);
  assign push         = p2_q;
  assign bus.rsp_valid = rsta_n & ~fifo_empty;
  assign bus.rsp_data  = fifo_mem[rd_ptr_q];
  assign pop          = bus.rsp_valid & bus.rsp_ready;

  assign rd_count = rd_cnt_q;
  assign wr_count = wr_cnt_q;

  // Occupancy: reads accepted but not yet handed out on the response channel.
  always_ff @(posedge clka) begin
    if (!rsta_n) begin
      occ_q <= '0;
    end else if (rd_accept && !pop) begin
      occ_q <= occ_q + OCC_W'(1);
    end else if (!rd_accept && pop) begin
      occ_q <= occ_q - OCC_W'(1);
    end
  end

  // Read tag pipeline aligned with the RAM's 2-cycle output latency.
  always_ff @(posedge clka) begin
    if (!rsta_n) begin
      p1_q <= 1'b0;
      p2_q <= 1'b0;
    end else begin
      p1_q <= rd_accept;
      p2_q <= p1_q;
    end
  end

  // Response FIFO pointers and fill level; pointers wrap naturally.
  always_ff @(posedge clka) begin
    if (!rsta_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_cnt_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      if (push && !pop) begin
        fifo_cnt_q <= fifo_cnt_q + OCC_W'(1);
      end else if (!push && pop) begin
        fifo_cnt_q <= fifo_cnt_q - OCC_W'(1);
      end
    end
  end

  // Response FIFO storage; contents need no reset since the count gates them.
  always_ff @(posedge clka) begin
    if (rsta_n && push) begin
      fifo_mem[wr_ptr_q] <= ram_douta;
    end
  end

  // Accepted read / write counters, wrapping at 2^32.
  always_ff @(posedge clka) begin
    if (!rsta_n) begin
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
    end else begin
      if (rd_accept) rd_cnt_q <= rd_cnt_q + 32'd1;
      if (wr_accept) wr_cnt_q <= wr_cnt_q + 32'd1;
    end
  end

  // Occupancy accounting guarantees space for every push.
  a_no_overflow : assert property (@(posedge clka) disable iff (!rsta_n) !(push && fifo_full))
    else $error("response FIFO push while full");

endmodule

// File: tb/tb_bram_port_client.sv
// Bench for bram_port_client: behavioural RAM plus a transaction-level model
// (shadow memory and a queue of expected responses with their earliest cycle).
module tb_bram_port_client;
  localparam int DATA_W    = 18;
  localparam int ADDR_W    = 10;
  localparam int RSP_DEPTH = 4;

  logic              clka = 1'b0;
  logic              rsta_n = 1'b0;
  logic [ADDR_W-1:0] ram_addra;
  logic [DATA_W-1:0] ram_dina;
  logic              ram_wea, ram_ena, ram_rsta, ram_regcea;
  logic [DATA_W-1:0] ram_douta;
  logic [31:0]       rd_count, wr_count;

  bram_port_client_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  bram_port_client #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .RSP_DEPTH(RSP_DEPTH)) dut (
    .clka(clka), .rsta_n(rsta_n), .bus(bus),
    .ram_addra(ram_addra), .ram_dina(ram_dina), .ram_wea(ram_wea), .ram_ena(ram_ena),
    .ram_rsta(ram_rsta), .ram_regcea(ram_regcea), .ram_douta(ram_douta),
    .rd_count(rd_count), .wr_count(wr_count)
  );

  always #5 clka = ~clka;

  // Behavioural block RAM: read-first, address/data register plus output register.
  logic [DATA_W-1:0] ram [0:(1<<ADDR_W)-1];
  logic [DATA_W-1:0] ram_dreg;
  always @(posedge clka) begin
    if (ram_ena) begin
      if (ram_wea) ram[ram_addra] <= ram_dina;
      ram_dreg <= ram[ram_addra];
    end
    if (ram_rsta) ram_douta <= '0;
    else if (ram_regcea) ram_douta <= ram_dreg;
  end

  typedef struct {
    logic [DATA_W-1:0] d;
    int                t;
  } rsp_t;

  rsp_t              q[$];
  logic [DATA_W-1:0] shadow [int];
  logic [31:0]       rdc = '0;
  logic [31:0]       wrc = '0;
  int                cyc = 0;
  int                n_cmp = 0;
  int                n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive at the falling edge, check, then advance the model.
  task automatic step(input logic v, input logic we, input logic [ADDR_W-1:0] a,
                      input logic [DATA_W-1:0] d, input logic rr, output logic hs);
    logic exp_ready, exp_valid, acc;
    rsp_t e;
    bus.req_valid = v;
    bus.req_we    = we;
    bus.req_addr  = a;
    bus.req_wdata = d;
    bus.rsp_ready = rr;
    #1;
    exp_ready = (q.size() < RSP_DEPTH);
    exp_valid = (q.size() != 0) && (q[0].t <= cyc);
    chk("req_ready", bus.req_ready, exp_ready);
    chk("rsp_valid", bus.rsp_valid, exp_valid);
    if (exp_valid) chk("rsp_data", bus.rsp_data, q[0].d);
    chk("ram_ena", ram_ena, v & exp_ready);
    chk("ram_wea", ram_wea, v & exp_ready & we);
    chk("ram_rsta", ram_rsta, 1'b0);
    chk("ram_regcea", ram_regcea, 1'b1);
    if (v) begin
      chk("ram_addra", ram_addra, a);
      chk("ram_dina", ram_dina, d);
    end
    chk("rd_count", rd_count, rdc);
    chk("wr_count", wr_count, wrc);
    hs  = v & bus.req_ready;
    acc = v & exp_ready;
    if (exp_valid && rr) void'(q.pop_front());
    if (acc && !we) begin
      e.d = shadow[int'(a)];
      e.t = cyc + 3;
      q.push_back(e);
      rdc = rdc + 32'd1;
    end
    if (acc && we) begin
      shadow[int'(a)] = d;
      wrc = wrc + 32'd1;
    end
    @(negedge clka);
    cyc++;
  endtask

  task automatic idle(input int n, input logic rr);
    logic hs;
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, '0, rr, hs);
  endtask

  // Hold reset for n cycles while offering a write, then release it.
  task automatic do_reset(input int n);
    rsta_n        = 1'b0;
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b1;
    bus.req_addr  = ADDR_W'(7);
    bus.req_wdata = DATA_W'(18'h3ABCD);
    bus.rsp_ready = 1'b1;
    for (int i = 0; i < n; i++) begin
      #1;
      chk("rst_req_ready", bus.req_ready, 1'b0);
      chk("rst_rsp_valid", bus.rsp_valid, 1'b0);
      chk("rst_ram_ena", ram_ena, 1'b0);
      chk("rst_ram_wea", ram_wea, 1'b0);
      chk("rst_ram_rsta", ram_rsta, 1'b1);
      @(negedge clka);
      cyc++;
    end
    q.delete();
    rdc = '0;
    wrc = '0;
    rsta_n        = 1'b1;
    bus.req_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic hs;
    int   acc_n;
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.rsp_ready = 1'b0;
    @(negedge clka);
    do_reset(2);

    // Write then immediate read of the same address.
    step(1'b1, 1'b1, ADDR_W'(5), DATA_W'(18'h155), 1'b1, hs);
    step(1'b1, 1'b0, ADDR_W'(5), '0, 1'b1, hs);
    idle(4, 1'b1);
    chk("wr_then_rd_wr_count", wr_count, 32'd1);
    chk("wr_then_rd_rd_count", rd_count, 32'd1);

    // Preload addresses 0..31 with their own address.
    for (int i = 0; i < 32; i++) step(1'b1, 1'b1, ADDR_W'(i), DATA_W'(i), 1'b1, hs);

    // Back-to-back reads at full throughput.
    acc_n = 0;
    for (int i = 0; i < 16; i++) begin
      step(1'b1, 1'b0, ADDR_W'(i), '0, 1'b1, hs);
      if (hs) acc_n++;
    end
    chk("b2b_accepted", acc_n, 16);
    idle(5, 1'b1);

    // Backpressure: six reads offered with the response side stalled.
    acc_n = 0;
    for (int c = 0; c < 10; c++) begin
      step(acc_n < 6, 1'b0, ADDR_W'(10 + acc_n), '0, 1'b0, hs);
      if (hs) acc_n++;
    end
    chk("stall_accepted", acc_n, 4);
    for (int c = 0; c < 40 && (acc_n < 6 || q.size() != 0); c++) begin
      step(acc_n < 6, 1'b0, ADDR_W'(10 + acc_n), '0, 1'b1, hs);
      if (hs) acc_n++;
    end
    chk("stall_all_accepted", acc_n, 6);
    chk("stall_drained", q.size(), 0);
    idle(2, 1'b1);

    // Read accepted together with a pop at occupancy RSP_DEPTH-1.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, ADDR_W'(20 + i), '0, 1'b0, hs);
    step(1'b1, 1'b0, ADDR_W'(23), '0, 1'b1, hs);
    chk("pop_accept_hs", hs, 1'b1);
    step(1'b0, 1'b0, '0, '0, 1'b0, hs);
    idle(8, 1'b1);

    // Randomised traffic.
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
           ADDR_W'($urandom_range(0, 31)), DATA_W'($urandom), $urandom_range(0, 3) != 0, hs);
    end
    idle(8, 1'b1);

    // Reset with two reads in flight, then confirm RAM kept its contents.
    step(1'b1, 1'b1, ADDR_W'(40), DATA_W'(18'h2AAAA), 1'b1, hs);
    step(1'b1, 1'b0, ADDR_W'(1), '0, 1'b1, hs);
    step(1'b1, 1'b0, ADDR_W'(2), '0, 1'b1, hs);
    do_reset(1);
    idle(6, 1'b1);
    chk("post_rst_rd_count", rd_count, 32'd0);
    chk("post_rst_wr_count", wr_count, 32'd0);
    step(1'b1, 1'b0, ADDR_W'(40), '0, 1'b1, hs);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, ADDR_W'(i), '0, 1'b1, hs);
    idle(6, 1'b1);

    // Write counter wrap.
    force dut.wr_cnt_q = 32'hFFFF_FFFF;
    #1;
    release dut.wr_cnt_q;
    wrc = 32'hFFFF_FFFF;
    step(1'b1, 1'b1, ADDR_W'(41), DATA_W'(18'h00123), 1'b1, hs);
    idle(1, 1'b1);
    chk("wr_count_wrap", wr_count, 32'd0);
    step(1'b1, 1'b0, ADDR_W'(41), '0, 1'b1, hs);
    idle(5, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/bram_port_client.md
BRAM_PORT_CLIENT -- requirements
Module: bram_port_client

Interface
REQ-001 The module SHALL have parameter DATA_W, default 18: data width, equal to the attached RAM's RAM_WIDTH.
REQ-002 The module SHALL have parameter ADDR_W, default 10: address width, equal to the attached RAM's address width.
REQ-003 The module SHALL have parameter RSP_DEPTH, default 4: response FIFO depth; power of 2, minimum 4.
REQ-004 The module SHALL have port clka, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 The module SHALL have port rsta_n, input, 1 bit: reset, synchronous, active-low.
REQ-006 The module SHALL have ports req_valid (input, 1), req_ready (output, 1), req_we (input, 1), req_addr (input, ADDR_W), req_wdata (input, DATA_W): the access request channel.
REQ-007 The module SHALL have ports rsp_valid (output, 1), rsp_ready (input, 1), rsp_data (output, DATA_W): the read-response channel.
REQ-008 The module SHALL have ports ram_addra (output, ADDR_W), ram_dina (output, DATA_W), ram_wea (output, 1), ram_ena (output, 1), ram_rsta (output, 1), ram_regcea (output, 1): the RAM port drive.
REQ-009 The module SHALL have port ram_douta, input, DATA_W: the RAM output, with 2-cycle registered read latency and read-first behaviour.
REQ-010 The module SHALL have ports rd_count and wr_count, output, 32 bits each: accepted read and write counters.

Function
REQ-011 A request handshake SHALL be req_valid & req_ready in the same cycle; a response handshake SHALL be rsp_valid & rsp_ready.
REQ-012 ram_ena SHALL equal req_valid & req_ready combinationally; ram_wea = req_we & ram_ena; ram_addra = req_addr; ram_dina = req_wdata.
REQ-013 ram_regcea SHALL be constant 1; ram_rsta SHALL equal ~rsta_n.
REQ-014 An occupancy counter (0..RSP_DEPTH) SHALL track accepted reads not yet consumed on the response channel, in flight or in the FIFO.
- +1 on a read accept; -1 on a response handshake; both in the same cycle leaves it unchanged.
REQ-015 req_ready SHALL be 1 iff rsta_n=1 and occupancy < RSP_DEPTH, independent of req_we and req_valid.
REQ-016 Writes SHALL NOT be accepted when occupancy = RSP_DEPTH, to keep the request channel in order.
REQ-017 A 2-stage valid tag pipeline (p1, p2) SHALL track read accepts: p1 <= read accept; p2 <= p1.
REQ-018 When p2=1, ram_douta SHALL be pushed into the response FIFO at that clock edge.
REQ-019 By occupancy accounting the FIFO SHALL never overflow; an assertion SHALL flag a push when full.
REQ-020 Read latency SHALL be: read accepted in cycle t -> rsp_valid=1 with that data in cycle t+3 at the earliest.
REQ-021 Responses SHALL return in request order.
REQ-022 rsp_valid SHALL equal FIFO non-empty, and rsp_data SHALL equal the FIFO head.
REQ-023 rsp_data SHALL be stable while rsp_valid=1 and rsp_ready=0.
REQ-024 With rsp_ready held at 1 and continuous read requests, throughput SHALL be one read per cycle with req_ready never deasserting (steady occupancy 3).
REQ-025 A write followed by a read of the same address in the next cycle SHALL return the newly written data.
REQ-026 Writes SHALL produce no response.
REQ-027 FIFO pointers SHALL be log2(RSP_DEPTH) bits and wrap modulo RSP_DEPTH.
REQ-028 rd_count and wr_count SHALL increment on each accepted read or write respectively, and wrap from 2^32-1 to 0.

Reset
REQ-029 While rsta_n=0 the module SHALL drive: req_ready=0, rsp_valid=0, ram_ena=0, ram_wea=0, ram_rsta=1, occupancy=0, p1=p2=0, FIFO empty, rd_count=wr_count=0.
REQ-030 Reset asserted mid-operation SHALL discard in-flight and queued reads; no response for them SHALL appear after reset is released.
REQ-031 RAM contents SHALL NOT be affected by reset.
REQ-032 req_ready SHALL be 1 in the first cycle after rsta_n returns to 1.

Verification
REQ-033 Write 0x155 to addr 5, then read addr 5 in the next cycle -> rsp_data=0x155 exactly 3 cycles after the read accept; wr_count=1, rd_count=1.
REQ-034 16 back-to-back reads of addrs 0..15 preloaded with value=addr, rsp_ready=1 -> req_ready stays 1 and responses 0..15 arrive in order on consecutive cycles.
REQ-035 rsp_ready=0 with 6 reads offered -> exactly 4 accepted, then req_ready=0 and rsp_data holds the first value stable; raising rsp_ready drains 4 responses and the remaining 2 are then accepted.
REQ-036 Read accept simultaneous with a response pop at occupancy 4-1 -> occupancy unchanged and req_ready stays 1.
REQ-037 rsta_n pulsed low for 1 cycle with 2 reads in flight -> no rsp_valid afterwards, counters are 0, and the RAM still holds prior writes.
REQ-038 wr_count forced to 0xFFFFFFFF, then one write -> wr_count=0.
